// File: rtl/fir_out_buffer.sv
// fir_out_buffer
// Output stage behind the 3-tap FIR. It drops the first WARMUP accepted
// strobes after reset, which are the filter fill samples. Each later sample
// gets a rounding arithmetic right shift and is saturated to 8-bit signed.
// The {sat, data} result goes into a show-ahead FIFO that a valid/ready
// consumer drains. The FIR is never stalled: a sample that arrives while the
// FIFO is full and not popping is dropped and counted.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_en      upstream strobe, y valid this cycle
//   y          16-bit signed FIR sample
//   shift      rounding right-shift amount 0..15
//   out_valid  FIFO head valid
//   out_ready  consumer accepts head this cycle
//   out_data   8-bit signed head sample (0 while empty)
//   out_sat    head sample was clamped
//   level      FIFO occupancy 0..DEPTH
//   ovf_cnt    dropped-sample count, saturating at 255
module fir_out_buffer #(
  parameter int DEPTH  = 4,
  parameter int WARMUP = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_en,
  input  logic [15:0]              y,
  input  logic [3:0]               shift,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic                     out_sat,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               ovf_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
  localparam logic [WW-1:0] WU_DONE = WW'(WARMUP);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  // Scale with round-half-toward-+inf and clamp to [-128, 127]; returns {sat, data}.
  // 17 bits hold the worst case 32767 + 16384 without overflow.
  function automatic logic [8:0] scale_sample(input logic [15:0] s, input logic [3:0] sh);
    logic signed [16:0] ext;
    logic signed [16:0] bias;
    logic signed [16:0] shifted;
    logic [8:0]         res;
    ext = {s[15], s};
    if (sh == 4'd0) begin
      bias = 17'sd0;
    end else begin
      bias = 17'sd1 <<< (sh - 4'd1);
    end
    shifted = (ext + bias) >>> sh;
    if (shifted > 17'sd127) begin
      res = {1'b1, 8'h7F};
    end else if (shifted < -17'sd128) begin
      res = {1'b1, 8'h80};
    end else begin
      res = {1'b0, shifted[7:0]};
    end
    return res;
  endfunction

  logic [WW-1:0] wu_q, wu_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]    ovf_q, ovf_d;
  logic [8:0]    mem_q [DEPTH];

  logic       warm_done;
  logic       full;
  logic       pop;
  logic       push;
  logic       drop;
  logic [8:0] entry;
  logic [8:0] head;

  assign warm_done = (wu_q == WU_DONE);
  assign full      = (level_q == LVL_FULL);
  assign out_valid = (level_q != {LW{1'b0}});
  assign pop       = out_valid & out_ready;
  assign push      = in_en & warm_done & (~full | pop);
  assign drop      = in_en & warm_done & full & ~pop;
  assign entry     = scale_sample(y, shift);

  // Next-state for warmup counter, pointers, occupancy and drop counter.
  always_comb begin
    wu_d     = wu_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;

    if (in_en && !warm_done) begin
      wu_d = wu_q + WW'(1);
    end else begin
      wu_d = wu_q;
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (drop && (ovf_q != 8'hFF)) begin
      ovf_d = ovf_q + 8'd1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Control state registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wu_q     <= {WW{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {LW{1'b0}};
      ovf_q    <= 8'd0;
    end else begin
      wu_q     <= wu_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= entry;
    end
  end

  // Mask the head while empty so stale or unwritten storage never reaches the pins.
  assign head     = out_valid ? mem_q[rd_ptr_q] : 9'd0;
  assign out_data = head[7:0];
  assign out_sat  = head[8];
  assign level    = level_q;
  assign ovf_cnt  = ovf_q;

endmodule
